audio_i2s_tx: RTL
=================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Parameters
REQ-001 SHALL have parameter BCLK_DIV, default 4, meaning system clocks per BCLK half-period; legal range 2..255.
REQ-002 SHALL have parameter SIGNED_IN, default 0, meaning 0 = sample_in is unsigned offset-binary (NES mixer output), 1 = two's complement.

Interface
REQ-003 SHALL have port clock, input, 1, the single system clock (21.477 MHz NES domain); every register is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port sample_in, input, 16, mono PCM sample from the APU mixer.
REQ-006 SHALL have port sample_valid, input, 1, one-clock qualifier (run_nes enable) that sample_in is current.
REQ-007 SHALL have port mute, input, 1, forces transmitted data to zero.
REQ-008 SHALL have port i2s_bclk, output, 1, serial bit clock.
REQ-009 SHALL have port i2s_lrck, output, 1, word select (0 = left, 1 = right).
REQ-010 SHALL have port i2s_data, output, 1, serial data, MSB first.
REQ-011 SHALL have port frame_start, output, 1, one-clock pulse when a new stereo frame is loaded.

Function
REQ-012 SHALL capture sample_in into a hold register on every clock where sample_valid=1; otherwise the hold register keeps its value.
REQ-013 SHALL convert the hold value to signed when SIGNED_IN=0 by inverting bit 15 at capture; SIGNED_IN=1 stores it unchanged.
REQ-014 SHALL run a divider counter 0..BCLK_DIV-1; at terminal count it wraps to 0 and i2s_bclk toggles, so BCLK period = 2*BCLK_DIV clocks (default 8, 2.685 MHz).
REQ-015 SHALL define a "falling tick" as the clock where i2s_bclk toggles 1->0; all data/LRCK changes occur only on falling ticks.
REQ-016 SHALL keep a 5-bit bit counter advancing by 1 per falling tick, wrapping 31->0 (32 BCLKs per frame, LRCK = 83.9 kHz at defaults).
REQ-017 SHALL, on the falling tick entering bit count 0, load a 32-bit shift register with {S,S}, S = hold register (mono duplicated L and R), or 32'h0 if mute=1 on that clock, and pulse frame_start for exactly that clock.
REQ-018 SHALL, on every other falling tick, shift the register left by one, filling 0; i2s_data = shift register bit 31 at all times.
REQ-019 SHALL drive i2s_lrck to 1 on the falling tick entering bit count 15 and to 0 on the falling tick entering bit count 31, so LRCK leads each word MSB by one BCLK (Philips I2S).
REQ-020 SHALL take a sample_valid coinciding with the load tick into the hold register only after the load; the frame uses the prior hold value.
REQ-021 SHALL sample mute only on load ticks; mute changes mid-frame take effect at the next frame.
REQ-022 SHALL hold i2s_bclk, i2s_lrck, i2s_data constant between ticks (glitch-free registered outputs, no combinational path from inputs).

Reset
REQ-023 SHALL, while reset_n=0 at a clock edge, set i2s_bclk=0, i2s_lrck=0, i2s_data=0, frame_start=0, divider=0, bit counter=31, shift register=0, hold register=0 (after SIGNED_IN conversion, i.e. silence).
REQ-024 SHALL, on reset mid-frame, abort the frame immediately; the first falling tick after release (at clock 2*BCLK_DIV after release) enters bit count 0 and loads a frame.

Verification
REQ-025 Reset release, defaults -> i2s_bclk rises at clock 4, falls at clock 8 with frame_start=1 and data = bit 31 of 32'h0000_0000.
REQ-026 sample_in=16'hC000, sample_valid pulse, SIGNED_IN=0 -> next frame serialises 16'h4000 twice: bits 0100_0000_0000_0000 on L then R, i2s_lrck=1 from bit 15 through bit 30.
REQ-027 SIGNED_IN=1, sample_in=16'h8001 -> L and R words both 1000_0000_0000_0001; frame_start period = 256 clocks.
REQ-028 mute=1 asserted mid-frame with sample 16'h7FFF held -> current frame completes with 16'h7FFF data, following frame all zeros.
REQ-029 sample_valid with new value on the exact load-tick clock -> that frame carries old value, next frame the new value.
REQ-030 BCLK_DIV=2, reset_n pulsed low at bit count 20 -> outputs 0 next clock, next frame_start exactly 4 clocks after release.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// Mono-to-stereo Philips I2S transmitter for the NES audio path.
// All timing is derived from one system clock: a divider produces BCLK,
// and every data/LRCK change happens on the clock where BCLK falls.
module audio_i2s_tx #(
   parameter int BCLK_DIV  = 4,   // system clocks per BCLK half-period, 2..255
   parameter int SIGNED_IN = 0    // 0: offset-binary input, 1: two's complement
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] sample_in,
   input  logic        sample_valid,
   input  logic        mute,
   output logic        i2s_bclk,
   output logic        i2s_lrck,
   output logic        i2s_data,
   output logic        frame_start
);

   localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

   logic [7:0]  div_cnt;
   logic        bclk_q;
   logic        lrck_q;
   logic        frame_start_q;
   logic [4:0]  bit_cnt;
   logic [31:0] shift_q;
   logic [15:0] hold_q;

   logic        div_wrap;
   logic        fall_tick;
   logic        load_tick;
   logic [15:0] captured;

   // The divider wraps every BCLK_DIV clocks; the wrap where BCLK is high is
   // the falling tick, and the falling tick leaving bit 31 starts a new frame.
   assign div_wrap  = (div_cnt == DIV_LAST);
   assign fall_tick = div_wrap && bclk_q;
   assign load_tick = fall_tick && (bit_cnt == 5'd31);

   // Offset-binary silence is 16'h8000; flipping the MSB recentres it on zero.
   assign captured = (SIGNED_IN != 0) ? sample_in : {~sample_in[15], sample_in[14:0]};

   // Bit-clock divider: count to terminal, wrap and toggle BCLK.
   always_ff @(posedge clock) begin
      // NOTE: reset is synchronous, so it is tested inside the clocked block
      // and clock is the only event in the sensitivity list.
      if (!reset_n) begin
         div_cnt <= '0;
         bclk_q  <= 1'b0;
      end else if (div_wrap) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register sees the pre-edge value of every other register.
         div_cnt <= '0;
         bclk_q  <= ~bclk_q;
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

   // Sample hold register: captures (and converts) on every valid strobe.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         hold_q <= '0;
      end else if (sample_valid) begin
         hold_q <= captured;
      end
   end

   // Serialiser: bit counter, shift register, word select and frame pulse,
   // all advanced only on falling ticks.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         bit_cnt       <= 5'd31;
         shift_q       <= '0;
         lrck_q        <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         // NOTE: the pulse defaults low every clock; the later assignment on
         // the load tick wins, giving a single-clock pulse without extra logic.
         frame_start_q <= 1'b0;
         if (fall_tick) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (load_tick) begin
               // Hold value read here is the pre-edge one, so a strobe on the
               // same clock lands in the following frame.
               shift_q       <= mute ? 32'h0 : {hold_q, hold_q};
               frame_start_q <= 1'b1;
            end else begin
               shift_q <= {shift_q[30:0], 1'b0};
            end
            // LRCK switches one BCLK ahead of each word MSB.
            if (bit_cnt == 5'd14) begin
               lrck_q <= 1'b1;
            end else if (bit_cnt == 5'd30) begin
               lrck_q <= 1'b0;
            end
         end
      end
   end

   assign i2s_bclk    = bclk_q;
   assign i2s_lrck    = lrck_q;
   assign i2s_data    = shift_q[31];
   assign frame_start = frame_start_q;

endmodule
